ahb_lite_manager: RTL

//  Request/response-to-AHB-Lite initiator: turns single-beat valid/ready requests into AHB-Lite

---
 rtl/ahb_pkg.sv | 49 ++++
 rtl/ahb_mgr_rsp_fifo.sv | 76 +++++++
 rtl/ahb_lite_manager.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite types and constants for ahb_lite_manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Response payload width; the manager's data width must match it.
    localparam int RSP_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      err;
        logic [RSP_DATA_WIDTH-1:0] rdata;
    } ahb_rsp_t;

    // True when a transfer of the given hsize is wider than the bus or
    // the address is not a multiple of the transfer size.
    function automatic logic ahb_misaligned(
        input logic [2:0] size,
        input logic [6:0] addr_lsb,
        input logic [2:0] max_size
    );
        logic [6:0] mask;
        mask = 7'((8'd1 << size) - 8'd1);
        return (size > max_size) || ((addr_lsb & mask) != 7'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mgr_rsp_fifo.sv
// ============================================================================
// Module      : ahb_mgr_rsp_fifo
// Description : Synchronous response FIFO holding ahb_rsp_t entries with an
//               occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_mgr_rsp_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  ahb_rsp_t         i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output ahb_rsp_t         o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    ahb_rsp_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The manager's credit rule must never let a push land on a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(i_push && !w_pop && (r_count == CNT_W'(DEPTH))));
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ahb_lite_manager.sv
// ============================================================================
// Module      : ahb_lite_manager
// Description : Valid/ready request to AHB-Lite NONSEQ SINGLE initiator with
//               pipelined address/data phases and in-order responses.
//               Optional: AHB_MGR_ALIGN_CHECK_EN turns oversize/misaligned
//               requests into local-error bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_manager
    import ahb_pkg::*;
#(
    parameter int         AHBAddrWidth = 32,
    parameter int         AHBDataWidth = 32,
    parameter int         RspDepth     = 4,
    parameter logic [3:0] HProt        = 4'b0011
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [AHBAddrWidth-1:0] req_addr_i,
    input  logic [2:0]              req_size_i,
    input  logic [AHBDataWidth-1:0] req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [AHBDataWidth-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [AHBAddrWidth-1:0] haddr_o,
    output logic                    hwrite_o,
    output logic [1:0]              htrans_o,
    output logic [2:0]              hsize_o,
    output logic [2:0]              hburst_o,
    output logic [3:0]              hprot_o,
    output logic                    hmastlock_o,
    output logic [AHBDataWidth-1:0] hwdata_o,
    input  logic [AHBDataWidth-1:0] hrdata_i,
    input  logic                    hready_i,
    input  logic                    hresp_i
);

    localparam int CNT_W = $clog2(RspDepth + 1);

    // Address-phase stage; haddr/hwrite/hsize/htrans are driven directly from it.
    logic                    r_a_valid;
    logic                    r_a_lerr;
    htrans_e                 r_htrans;
    logic [AHBAddrWidth-1:0] r_haddr;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic [AHBDataWidth-1:0] r_a_wdata;

    // Data-phase stage.
    logic                    r_d_valid;
    logic                    r_d_write;
    logic                    r_d_lerr;
    logic [AHBDataWidth-1:0] r_hwdata;

    logic                    w_accept;
    logic                    w_req_lerr;
    logic                    w_push;
    logic                    w_push_err;
    ahb_rsp_t                w_push_rsp;
    ahb_rsp_t                w_head;
    logic                    w_fifo_valid;
    logic [CNT_W-1:0]        w_fifo_count;
    logic [CNT_W:0]          w_occupancy;

`ifdef AHB_MGR_ALIGN_CHECK_EN
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AHBDataWidth / 8));
    assign w_req_lerr = ahb_misaligned(req_size_i, req_addr_i[6:0], MAX_SIZE);
`else
    assign w_req_lerr = 1'b0;
`endif

    // Every slot in A, D or the FIFO is a reserved response credit.
    assign w_occupancy = (CNT_W+1)'(r_a_valid) + (CNT_W+1)'(r_d_valid)
                       + (CNT_W+1)'(w_fifo_count);
    assign req_ready_o = (~r_a_valid | hready_i)
                       & (w_occupancy < (CNT_W+1)'(RspDepth));
    assign w_accept    = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_a_valid <= 1'b0;
            r_a_lerr  <= 1'b0;
            r_htrans  <= HTRANS_IDLE;
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_hsize   <= '0;
            r_a_wdata <= '0;
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_d_lerr  <= 1'b0;
            r_hwdata  <= '0;
        end else begin
            if (w_accept) begin
                r_a_valid <= 1'b1;
                r_a_lerr  <= w_req_lerr;
                r_htrans  <= w_req_lerr ? HTRANS_IDLE : HTRANS_NONSEQ;
                r_haddr   <= req_addr_i;
                r_hwrite  <= req_write_i;
                r_hsize   <= req_size_i;
                r_a_wdata <= req_wdata_i;
            end else if (hready_i) begin
                r_a_valid <= 1'b0;
                r_htrans  <= HTRANS_IDLE;
            end

            // hready_i both retires the data phase and advances the address phase.
            if (hready_i) begin
                r_d_valid <= r_a_valid;
                r_d_write <= r_hwrite;
                r_d_lerr  <= r_a_lerr;
                r_hwdata  <= r_a_wdata;
            end
        end
    end

    assign w_push           = r_d_valid & hready_i;
    assign w_push_err       = r_d_lerr | (hresp_i == HRESP_ERROR);
    assign w_push_rsp.err   = w_push_err;
    assign w_push_rsp.rdata = (r_d_write | w_push_err) ? '0 : hrdata_i;

    ahb_mgr_rsp_fifo #(
        .DEPTH   (RspDepth),
        .CNT_W   (CNT_W)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_push_rsp),
        .i_pop   (rsp_ready_i),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign rsp_valid_o = w_fifo_valid;
    assign rsp_rdata_o = w_head.rdata;
    assign rsp_err_o   = w_head.err;

    assign haddr_o     = r_haddr;
    assign hwrite_o    = r_hwrite;
    assign htrans_o    = r_htrans;
    assign hsize_o     = r_hsize;
    assign hwdata_o    = r_hwdata;
    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HProt;
    assign hmastlock_o = 1'b0;

endmodule

`default_nettype wire
